// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Shared definitions for the ALU issue/writeback sequencer.
//          - Default data width (W) and repeat-count width (CNT_W).
//          - The 3-bit ALU function encodings.
//          - The sequencer FSM state type and its state constants.
//          - A helper that tells which ops honour the repeat count.
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int W     = 16;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    INC = 3'b010,
    SHL = 3'b011,
    SHR = 3'b100,
    AND = 3'b101,
    ORR = 3'b110,
    NOT = 3'b111
  } func_e;

  // Sequencer FSM state type and its encodings.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Only the single-step ops are iterated; every other op runs once.
  function automatic logic is_iter(input logic [2:0] f);
    return (f == INC) || (f == SHL) || (f == SHR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_if
// Brief  : Bus bundle between a requester, the alu_seq sequencer and the ALU.
//          Request channel : req_valid/req_ready, req_func, req_a, req_b, req_cnt
//          Response channel: rsp_valid/rsp_ready, rsp_r, rsp_z, rsp_n, rsp_c
//          ALU drive       : alu_func, alu_a, alu_b (to ALU)
//                            alu_r, alu_z, alu_n, alu_c (from ALU)
//          Status          : busy
//          Modports:
//            slave  - the sequencer side
//            master - the requester / datapath side (also closes the ALU loop)
// Rev    : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
  parameter int W     = alu_pkg::W,
  parameter int CNT_W = alu_pkg::CNT_W
);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_func;
  logic [W-1:0]     req_a;
  logic [W-1:0]     req_b;
  logic [CNT_W-1:0] req_cnt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_r;
  logic             rsp_z;
  logic             rsp_n;
  logic             rsp_c;

  logic [2:0]       alu_func;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [W-1:0]     alu_r;
  logic             alu_z;
  logic             alu_n;
  logic             alu_c;

  logic             busy;

  modport slave (
    input  req_valid, req_func, req_a, req_b, req_cnt,
    output req_ready,
    output rsp_valid, rsp_r, rsp_z, rsp_n, rsp_c,
    input  rsp_ready,
    output alu_func, alu_a, alu_b,
    input  alu_r, alu_z, alu_n, alu_c,
    output busy
  );

  modport master (
    output req_valid, req_func, req_a, req_b, req_cnt,
    input  req_ready,
    input  rsp_valid, rsp_r, rsp_z, rsp_n, rsp_c,
    output rsp_ready,
    input  alu_func, alu_a, alu_b,
    output alu_r, alu_z, alu_n, alu_c,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module : alu_seq
// Brief  : Issue/writeback sequencer on the driving side of the ALU.
//          Accepts an op, drives the ALU from registers, iterates
//          SHL/SHR/INC up to 15 times, then returns result and flags.
//          Ports:
//            clk - clock, rising edge
//            rst - asynchronous active-high reset
//            bus - alu_seq_if.slave (request, response, ALU drive, busy)
//          Optional feature macro: ALU_SEQ_B2B_EN
//            When defined, a new request may be accepted in DONE during
//            the response handshake, going straight back to EXEC.
// Rev    : 1.0  initial release
// ============================================================================
module alu_seq #(
  parameter int W     = alu_pkg::W,
  parameter int CNT_W = alu_pkg::CNT_W
) (
  input  wire logic  clk,
  input  wire logic  rst,
  alu_seq_if.slave   bus
);

  import alu_pkg::*;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q,   acc_d;
  logic [W-1:0]     b_q,     b_d;
  logic [2:0]       func_q,  func_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic             z_q,     z_d;
  logic             n_q,     n_d;
  logic             c_q,     c_d;

  logic             rsp_hs;
  logic             req_rdy;
  logic             accept;
  logic [CNT_W-1:0] load_cnt;

  assign rsp_hs = (state_q == ST_DONE) && bus.rsp_ready;

`ifdef ALU_SEQ_B2B_EN
  // A response leaving DONE frees the sequencer in the same cycle.
  assign req_rdy = !rst && ((state_q == ST_IDLE) || rsp_hs);
`else
  assign req_rdy = !rst && (state_q == ST_IDLE);
`endif

  assign accept = bus.req_valid && req_rdy;

  // Iterated ops run max(cnt,1) times; all others run exactly once.
  always_comb begin
    load_cnt = CNT_W'(1);
    if (is_iter(bus.req_func) && (bus.req_cnt != '0)) begin
      load_cnt = bus.req_cnt;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    func_d  = func_q;
    rem_d   = rem_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;

    case (state_q)
      ST_IDLE: begin
        // Loading is handled below, shared with the DONE overlap case.
      end
      ST_EXEC: begin
        acc_d = bus.alu_r;
        z_d   = bus.alu_z;
        n_d   = bus.alu_n;
        // INC keeps carry sticky so a wrap in any iteration is reported;
        // shifts report only the bit shifted out on the final step.
        c_d   = (func_q == INC) ? (c_q | bus.alu_c) : bus.alu_c;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // accept can only be true in IDLE, or in DONE during the response
    // handshake when back-to-back issue is enabled.
    if (accept) begin
      acc_d   = bus.req_a;
      b_d     = bus.req_b;
      func_d  = bus.req_func;
      rem_d   = load_cnt;
      z_d     = 1'b0;
      n_d     = 1'b0;
      c_d     = 1'b0;
      state_d = ST_EXEC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      func_q  <= '0;
      rem_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      func_q  <= func_d;
      rem_q   <= rem_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
    end
  end

  // ALU is driven purely from registers; no path from req_* to alu_*.
  assign bus.alu_func  = func_q;
  assign bus.alu_a     = acc_q;
  assign bus.alu_b     = b_q;

  assign bus.req_ready = req_rdy;
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_r     = acc_q;
  assign bus.rsp_z     = z_q;
  assign bus.rsp_n     = n_q;
  assign bus.rsp_c     = c_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
